// File: rtl/rr_req_encoder4to2_pkg.sv
// Shared constants, FSM state type and one-hot helper for the round-robin
// request encoder.
package rr_enc_pkg;

  localparam int REQ_N  = 4;
  localparam int CODE_W = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_e;

  function automatic logic [REQ_N-1:0] onehot_of(input logic [CODE_W-1:0] code);
    logic [REQ_N-1:0] oh;
    oh       = '0;
    oh[code] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/rr_req_encoder4to2_if.sv
// Offer handshake between the encoder (master) and its consumer (slave).
interface rr_req_encoder4to2_if
  import rr_enc_pkg::*;
  ();

  logic              valid_o;
  logic              ready_i;
  logic [CODE_W-1:0] code_o;
  logic [REQ_N-1:0]  grant_o;

  modport master (output valid_o, output code_o, output grant_o, input ready_i);
  modport slave  (input valid_o, input code_o, input grant_o, output ready_i);

endinterface

// File: rtl/rr_req_encoder4to2_pick4.sv
// Wrap-around priority search: first set bit of cand_i at or after ptr_i.
module rr_pick4
  import rr_enc_pkg::*;
(
  input  logic [REQ_N-1:0]  cand_i,
  input  logic [CODE_W-1:0] ptr_i,
  output logic [CODE_W-1:0] idx_o,
  output logic              any_o
);

  logic [2*REQ_N-1:0] dbl;
  logic [REQ_N-1:0]   rot;
  logic [CODE_W-1:0]  off;

  // Rotating the candidates so bit 0 is the pointer position turns the
  // round-robin search into a plain lowest-set-bit search.
  assign dbl = {cand_i, cand_i};
  assign rot = REQ_N'(dbl >> ptr_i);

  // Lowest set bit of the rotated vector, scanned high to low so the last hit wins.
  always_comb begin
    off = '0;
    for (int j = REQ_N - 1; j >= 0; j--) begin
      if (rot[j]) off = CODE_W'(j);
    end
  end

  assign idx_o = ptr_i + off;
  assign any_o = |cand_i;

endmodule

// File: rtl/rr_req_encoder4to2.sv
// Request capture and round-robin offer stage feeding the 4-to-2 encoder.
//
// state | meaning
// IDLE  | nothing offered, waiting for a pending request or new edge
// OFFER | code/grant held stable until the consumer accepts
module rr_req_encoder4to2
  import rr_enc_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [REQ_N-1:0]     req,
  rr_req_encoder4to2_if.master bus,
  output logic [REQ_N-1:0]     pending_o,
  output logic                 dropped_o
);

  state_e            state_q, state_d;
  logic [REQ_N-1:0]  req_q;
  logic [REQ_N-1:0]  pending_q, pending_d;
  logic [CODE_W-1:0] ptr_q, ptr_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic [REQ_N-1:0]  grant_q, grant_d;
  logic              valid_q, valid_d;
  logic              dropped_q, dropped_d;

  logic [REQ_N-1:0]  evt;
  logic [REQ_N-1:0]  cand;
  logic              accept;
  logic [CODE_W-1:0] pick_ptr;
  logic [CODE_W-1:0] pick_idx;
  logic              pick_any;

  assign evt    = req & ~req_q;
  assign cand   = pending_q | evt;
  assign accept = valid_q & bus.ready_i;

  // On accept the next pick already searches from the advanced pointer,
  // which is what makes back-to-back offers fair.
  assign pick_ptr = accept ? code_q + CODE_W'(1) : ptr_q;

  rr_pick4 u_pick (
    .cand_i (cand),
    .ptr_i  (pick_ptr),
    .idx_o  (pick_idx),
    .any_o  (pick_any)
  );

  // Next-state logic for the offer FSM, pending set and drop pulse.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    code_d    = code_q;
    grant_d   = grant_q;
    valid_d   = valid_q;
    pending_d = pending_q;
    dropped_d = |(evt & pending_q);
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d   = OFFER;
          valid_d   = 1'b1;
          code_d    = pick_idx;
          grant_d   = onehot_of(pick_idx);
          pending_d = cand & ~onehot_of(pick_idx);
        end
      end
      OFFER: begin
        if (accept) begin
          ptr_d = pick_ptr;
          if (pick_any) begin
            code_d    = pick_idx;
            grant_d   = onehot_of(pick_idx);
            pending_d = cand & ~onehot_of(pick_idx);
          end else begin
            state_d   = IDLE;
            valid_d   = 1'b0;
            grant_d   = '0;
            pending_d = '0;
          end
        end else begin
          // A new edge on the index still waiting for accept is merged, not queued.
          pending_d = pending_q | (evt & ~grant_q);
          dropped_d = |(evt & (pending_q | grant_q));
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        grant_d = '0;
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      req_q     <= '0;
      pending_q <= '0;
      ptr_q     <= '0;
      code_q    <= '0;
      grant_q   <= '0;
      valid_q   <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req;
      pending_q <= pending_d;
      ptr_q     <= ptr_d;
      code_q    <= code_d;
      grant_q   <= grant_d;
      valid_q   <= valid_d;
      dropped_q <= dropped_d;
    end
  end

  assign bus.valid_o = valid_q;
  assign bus.code_o  = code_q;
  assign bus.grant_o = grant_q;
  assign pending_o   = pending_q;
  assign dropped_o   = dropped_q;

endmodule

// File: tb/tb_rr_req_encoder4to2.sv
// Bench for rr_req_encoder4to2: directed scenarios with literal expectations,
// then randomized traffic, all compared every cycle against a request-set model.
module tb_rr_req_encoder4to2;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] pending_o;
  logic       dropped_o;

  rr_req_encoder4to2_if bus_if ();

  rr_req_encoder4to2 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .bus       (bus_if),
    .pending_o (pending_o),
    .dropped_o (dropped_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: which requests are waiting, which one is offered, and the fairness pointer.
  bit       m_valid;
  int       m_code;
  int       m_ptr;
  bit [3:0] m_pend;
  bit       m_drop;
  bit [3:0] m_rq;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic int pick(input bit [3:0] c, input int p);
    for (int k = 0; k < 4; k++) begin
      if (c[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_code = 0; m_ptr = 0; m_pend = 0; m_drop = 0; m_rq = 0;
  endtask

  task automatic model_step();
    bit [3:0] evt, cand;
    int p;
    if (!rst_n) begin
      model_reset();
      return;
    end
    evt    = req & ~m_rq;
    cand   = m_pend | evt;
    m_drop = |(evt & m_pend);
    if (!m_valid) begin
      p = pick(cand, m_ptr);
      if (p >= 0) begin
        m_valid = 1; m_code = p; m_pend = cand; m_pend[p] = 0;
      end
    end else if (bus_if.ready_i) begin
      m_ptr = (m_code + 1) % 4;
      p = pick(cand, m_ptr);
      if (p >= 0) begin
        m_code = p; m_pend = cand; m_pend[p] = 0;
      end else begin
        m_valid = 0; m_pend = 0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (evt[i]) begin
          if (m_pend[i] || i == m_code) m_drop = 1;
          else m_pend[i] = 1;
        end
      end
    end
    m_rq = req;
  endtask

  task automatic cmp_model();
    chk("valid", bus_if.valid_o, m_valid);
    if (m_valid) chk("code", bus_if.code_o, m_code);
    chk("grant", bus_if.grant_o, m_valid ? (32'd1 << m_code) : 32'd0);
    chk("pending", pending_o, m_pend);
    chk("dropped", dropped_o, m_drop);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    cmp_model();
  endtask

  task automatic assert_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    cmp_model();
    chk("rst_valid", bus_if.valid_o, 0);
    chk("rst_grant", bus_if.grant_o, 0);
    chk("rst_pending", pending_o, 0);
  endtask

  initial begin
    bit [3:0] exp_pend[4];
    exp_pend = '{4'b1110, 4'b1100, 4'b1000, 4'b0000};
    model_reset();
    rst_n = 1'b0;
    req = 4'b0000;
    bus_if.ready_i = 1'b1;
    #3;
    cmp_model();
    chk("rst_code", bus_if.code_o, 0);
    chk("rst_dropped", dropped_o, 0);
    cyc(); cyc();
    rst_n = 1'b1;
    cyc(); cyc();
    chk("idle_after_rel", bus_if.valid_o, 0);

    // Single request on line 2.
    req = 4'b0100;
    cyc();
    chk("single_valid", bus_if.valid_o, 1);
    chk("single_code", bus_if.code_o, 2);
    chk("single_grant", bus_if.grant_o, 4'b0100);
    cyc();
    chk("single_done", bus_if.valid_o, 0);
    req = 4'b0000;
    cyc();

    // Burst from a fresh pointer.
    assert_reset();
    cyc();
    rst_n = 1'b1;
    cyc();
    req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("burst_valid", bus_if.valid_o, 1);
      chk("burst_code", bus_if.code_o, i);
      chk("burst_pend", pending_o, exp_pend[i]);
    end
    cyc();
    chk("burst_end", bus_if.valid_o, 0);
    req = 4'b0000;
    cyc();

    // Wrap-around: accept code 1, then events on lines 0 and 3 together.
    req = 4'b0010;
    cyc();
    chk("wrap_pre_code", bus_if.code_o, 1);
    req = 4'b0000;
    cyc();
    req = 4'b1001;
    cyc();
    chk("wrap_code3", bus_if.code_o, 3);
    chk("wrap_pend", pending_o, 4'b0001);
    cyc();
    chk("wrap_code0", bus_if.code_o, 0);
    chk("wrap_valid", bus_if.valid_o, 1);
    req = 4'b0000;
    cyc();
    chk("wrap_end", bus_if.valid_o, 0);

    // Backpressure with a re-request on the offered line.
    bus_if.ready_i = 1'b0;
    req = 4'b0010;
    cyc();
    chk("bp_code", bus_if.code_o, 1);
    for (int s = 0; s < 5; s++) begin
      req = (s == 1) ? 4'b0000 : 4'b0010;
      cyc();
      chk("bp_stable_valid", bus_if.valid_o, 1);
      chk("bp_stable_code", bus_if.code_o, 1);
      chk("bp_drop", dropped_o, (s == 2) ? 1 : 0);
    end
    bus_if.ready_i = 1'b1;
    cyc();
    chk("bp_one_grant", bus_if.valid_o, 0);
    chk("bp_pend1", pending_o[1], 0);
    cyc();
    chk("bp_no_regrant", bus_if.valid_o, 0);
    req = 4'b0000;
    cyc();

    // Reset in the middle of an offer, request held through release.
    bus_if.ready_i = 1'b0;
    req = 4'b1000;
    cyc();
    chk("mid_code", bus_if.code_o, 3);
    chk("mid_valid", bus_if.valid_o, 1);
    assert_reset();
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("mid_rel_valid", bus_if.valid_o, 1);
    chk("mid_rel_code", bus_if.code_o, 3);
    bus_if.ready_i = 1'b1;
    cyc();

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 2) == 0) req = 4'($urandom_range(0, 15));
      bus_if.ready_i = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 199) == 0) begin
        assert_reset();
        cyc();
        rst_n = 1'b1;
      end
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
